// File: rtl/wb_project_selector_pkg.sv
// Shared constants and types for the Wishbone project selector: register map,
// CTRL field layout and the guard FSM state encoding.
package wb_project_selector_pkg;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_SCRATCH = 8'h08;
  localparam logic [7:0] OFF_IO_LO   = 8'h0C;
  localparam logic [7:0] OFF_IO_HI   = 8'h10;

  localparam int CTRL_IDX_LSB = 0;
  localparam int CTRL_IDX_MSB = 3;
  localparam int CTRL_EN_BIT  = 8;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_GUARD = 2'd1,
    S_ON    = 2'd2
  } sel_state_e;

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
  } ctrl_t;

endpackage

// File: rtl/sel_guard_fsm.sv
// Break-before-make sequencer: holds every active line low for GUARD_CYCLES
// before raising the one-hot enable of a newly selected project.
module sel_guard_fsm
  import wb_project_selector_pkg::*;
#(
  parameter int NUM_PROJECTS = 8,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    target_valid_i,
  input  logic [3:0]              idx_i,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    busy_o,
  output sel_state_e              state_o
);

  localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0] GLOAD = CW'(GUARD_CYCLES - 1);

  sel_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!target_valid_i) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_GUARD;
          cnt_d   = GLOAD;
          idx_d   = idx_i;
        end
        S_GUARD: begin
          // A fresh valid write restarts the full guard interval.
          if (load_i) begin
            cnt_d = GLOAD;
            idx_d = idx_i;
          end else if (cnt_q == '0) begin
            state_d = S_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_ON: begin
          if (load_i && (idx_i != idx_q)) begin
            state_d = S_GUARD;
            cnt_d   = GLOAD;
            idx_d   = idx_i;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
    active_d = (state_d == S_ON) ? (NUM_PROJECTS'(1) << idx_d) : '0;
    busy_d   = (state_d == S_GUARD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      idx_q    <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      busy_q   <= busy_d;
    end
  end

  assign active_o = active_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;

endmodule

// File: rtl/wb_project_selector.sv
// Wishbone classic responder that selects which wrapped project owns the pads,
// with a guarded switchover and a synchronized io_in snapshot for debug.
module wb_project_selector
  import wb_project_selector_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          NUM_PROJECTS = 8,
  parameter int          GUARD_CYCLES = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [37:0]             io_in,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    busy_o
);

  logic             ack_q, load_q, lo_rd_q;
  logic [31:0]      dat_q, rdata;
  ctrl_t            ctrl_q, ctrl_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [1:0][37:0] sync_q;
  logic [37:0]      snap_q;
  logic             in_win, req, wr, rd, target_valid;
  logic [7:0]       off;
  sel_state_e       state;
  logic             unused_adr;

  assign in_win     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off        = {wbs_adr_i[7:2], 2'b00};
  assign req        = wbs_stb_i & wbs_cyc_i & ~ack_q & in_win;
  assign wr         = req & wbs_we_i;
  assign rd         = req & ~wbs_we_i;
  assign unused_adr = ^wbs_adr_i[1:0];

  assign target_valid = ctrl_q.en & ({1'b0, ctrl_q.idx} < 5'(NUM_PROJECTS));

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[CTRL_IDX_MSB:CTRL_IDX_LSB] = ctrl_q.idx;
        rdata[CTRL_EN_BIT]               = ctrl_q.en;
      end
      OFF_STATUS:  rdata = {13'd0, state, busy_o, 16'(active_o)};
      OFF_SCRATCH: rdata = scratch_q;
      OFF_IO_LO:   rdata = snap_q[31:0];
      OFF_IO_HI:   rdata = {26'd0, snap_q[37:32]};
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    if (wr) begin
      case (off)
        OFF_CTRL: begin
          if (wbs_sel_i[CTRL_IDX_LSB/8]) ctrl_d.idx = wbs_dat_i[CTRL_IDX_MSB:CTRL_IDX_LSB];
          if (wbs_sel_i[CTRL_EN_BIT/8])  ctrl_d.en  = wbs_dat_i[CTRL_EN_BIT];
        end
        OFF_SCRATCH: begin
          for (int b = 0; b < 4; b++)
            if (wbs_sel_i[b]) scratch_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      load_q    <= 1'b0;
      lo_rd_q   <= 1'b0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      sync_q    <= '0;
      snap_q    <= '0;
    end else begin
      ack_q     <= req;
      dat_q     <= rd ? rdata : '0;
      load_q    <= wr & (off == OFF_CTRL);
      lo_rd_q   <= rd & (off == OFF_IO_LO);
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      sync_q    <= {sync_q[0], io_in};
      // Hold the snapshot through an IO_LO ack so IO_HI reads the same sample.
      if (!(ack_q & lo_rd_q)) snap_q <= sync_q[1];
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  sel_guard_fsm #(
    .NUM_PROJECTS (NUM_PROJECTS),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_fsm (
    .clk            (wb_clk_i),
    .rst_n          (wb_rst_n),
    .load_i         (load_q),
    .target_valid_i (target_valid),
    .idx_i          (ctrl_q.idx),
    .active_o       (active_o),
    .busy_o         (busy_o),
    .state_o        (state)
  );

endmodule

// File: tb/tb_wb_project_selector.sv
// Directed bench for wb_project_selector: register table plus guard/switch,
// snapshot and mid-transaction reset sequences.
module tb_wb_project_selector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] dat_o;
  logic [37:0] io_in;
  logic [7:0]  active;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] prev_active;

  always #5 clk = ~clk;

  wb_project_selector dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .io_in     (io_in),
    .active_o  (active),
    .busy_o    (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output bit acked, output int lat);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0; rd = '0; lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin
        acked = 1'b1;
        rd = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [31:0] d, input string nm);
    logic [31:0] r; bit a; int l;
    wb_xfer(1'b1, 32'h3000_0000, d, 4'hF, r, a, l);
    chk({nm, "_ack"}, {31'd0, a}, 32'd1);
  endtask

  // Expect n guard cycles (busy, no active line) then the given active value.
  task automatic expect_guard(input string nm, input int n, input logic [7:0] fin);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!busy || active != 8'h00) bad++;
    end
    chk({nm, "_guard_cycles_bad"}, bad, 0);
    @(posedge clk); #1;
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({nm, "_active_after"}, {24'd0, active}, {24'd0, fin});
  endtask

  // Never more than one line, never a direct hop between two projects.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_active <= '0;
    end else begin
      checks++;
      if ($countones(active) > 1 ||
          (prev_active != 8'h00 && active != 8'h00 && active != prev_active)) begin
        failures++;
        $display("FAIL active_invariant actual=%h required_prev=%h", active, prev_active);
      end
      prev_active <= active;
    end
  end

  typedef struct {
    string       nm;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  initial begin
    vec_t        tbl[12];
    logic [31:0] r;
    bit          a;
    int          l;

    rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0; io_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_active", {24'd0, active}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, r, a, l);
    chk("status0_lat", l, 1);
    chk("status0_dat", r, 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);
    chk("dat_zero_outside_ack", dat_o, 32'd0);

    tbl[0]  = '{"rd_ctrl0",      0, 32'h3000_0000, 32'h0,        4'hF, 1, 32'h0};
    tbl[1]  = '{"wr_scratch",    1, 32'h3000_0008, 32'hDEADBEEF, 4'b0101, 1, 32'h0};
    tbl[2]  = '{"rd_scratch",    0, 32'h3000_0008, 32'h0,        4'hF, 1, 32'h00AD00EF};
    tbl[3]  = '{"rd_unmapped",   0, 32'h3000_0020, 32'h0,        4'hF, 1, 32'h0};
    tbl[4]  = '{"wr_unmapped",   1, 32'h3000_0024, 32'hFFFFFFFF, 4'hF, 1, 32'h0};
    tbl[5]  = '{"rd_outside",    0, 32'h3000_0108, 32'h0,        4'hF, 0, 32'h0};
    tbl[6]  = '{"wr_outside",    1, 32'h4000_0008, 32'h12345678, 4'hF, 0, 32'h0};
    tbl[7]  = '{"rd_scratch2",   0, 32'h3000_0008, 32'h0,        4'hF, 1, 32'h00AD00EF};
    tbl[8]  = '{"wr_ctrl_oor",   1, 32'h3000_0000, 32'h0000010A, 4'hF, 1, 32'h0};
    tbl[9]  = '{"rd_ctrl_oor",   0, 32'h3000_0000, 32'h0,        4'hF, 1, 32'h0000010A};
    tbl[10] = '{"rd_status_oor", 0, 32'h3000_0004, 32'h0,        4'hF, 1, 32'h0};
    tbl[11] = '{"rd_io_lo0",     0, 32'h3000_000C, 32'h0,        4'hF, 1, 32'h0};

    foreach (tbl[i]) begin
      wb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, r, a, l);
      chk({tbl[i].nm, "_ack"}, {31'd0, a}, {31'd0, tbl[i].exp_ack});
      if (tbl[i].exp_ack && !tbl[i].w) chk({tbl[i].nm, "_dat"}, r, tbl[i].exp_dat);
    end
    chk("oor_active", {24'd0, active}, 32'd0);

    // Select project 3 from OFF.
    wr_ctrl(32'h103, "sel3");
    expect_guard("sel3", 16, 8'h08);
    wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, r, a, l);
    chk("status_on3", r, 32'h0004_0008);

    // Switch 3 -> 5: full guard, no overlap.
    wr_ctrl(32'h105, "sel5");
    expect_guard("sel5", 16, 8'h20);

    // Same index rewrite keeps the project on with no guard.
    wr_ctrl(32'h105, "same5");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("same5_active", {24'd0, active}, 32'h20);
      chk("same5_busy", {31'd0, busy}, 32'd0);
    end

    // Disable during guard: straight to OFF.
    wr_ctrl(32'h102, "sel2");
    repeat (5) @(posedge clk);
    wr_ctrl(32'h000, "dis");
    @(posedge clk); #1;
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_active", {24'd0, active}, 32'd0);
    wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, r, a, l);
    chk("status_off", r, 32'd0);

    // A valid write mid-guard restarts the interval at the new index.
    wr_ctrl(32'h101, "sel1");
    repeat (5) @(posedge clk);
    wr_ctrl(32'h104, "reload4");
    expect_guard("reload4", 16, 8'h10);

    // Coherent io_in snapshot across IO_LO / IO_HI.
    io_in = 38'h2A_1234_5678;
    repeat (3) @(posedge clk);
    wb_xfer(1'b0, 32'h3000_000C, 32'd0, 4'hF, r, a, l);
    chk("io_lo", r, 32'h1234_5678);
    io_in = 38'h15_8765_4321;
    wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, a, l);
    chk("io_hi_frozen", r, 32'h0000_002A);
    repeat (4) @(posedge clk);
    wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, a, l);
    chk("io_hi_new", r, 32'h0000_0015);

    // Reset with a request pending and a project on: nothing is acked.
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0004;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_active", {24'd0, active}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ack", {31'd0, ack}, 32'd0);
    chk("postrst_active", {24'd0, active}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_project_selector.md
Name: wb_project_selector

Overview:
- Wishbone classic responder on the management bus. Drives the one-hot `active` lines that choose which wrapped project owns the shared io_out/io_oeb pins; it is the control-side counterpart of the per-project `active` inputs.
- Enforces a break-before-make guard interval on every project switch, so two projects never drive the pads at the same time.
- Provides a synchronized snapshot of io_in for firmware debug.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address; a register is decoded on adr[31:8] == BASE_ADDR[31:8].
- NUM_PROJECTS, 8, width of active_o; legal range 2..16.
- GUARD_CYCLES, 16, number of cycles all active lines are held low between deselect and select; minimum 1.

Ports:
- wb_clk_i  input  1  sole clock
- wb_rst_n  input  1  asynchronous active-low reset
- wbs_stb_i  input  1  strobe
- wbs_cyc_i  input  1  bus cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte lane select
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- io_in  input  38  pad inputs, asynchronous to the clock
- active_o  output  NUM_PROJECTS  one-hot project enable; all-zero means no project is selected
- busy_o  output  1  high while in GUARD

Behaviour:
- Reset values (async assert, sync release): wbs_ack_o=0, wbs_dat_o=0, active_o=0, busy_o=0, CTRL=0, SCRATCH=0, snapshot=0, FSM=OFF.
- Bus handshake:
  - A request is valid when stb & cyc & !ack; ack goes high the following cycle for exactly 1 cycle.
  - Back-to-back requests are therefore acked at most every other cycle.
  - Read data is valid in the ack cycle and is 0 outside it.
  - A request outside the BASE_ADDR window is ignored (no ack).
  - An unmapped offset inside the window is acked; reads return 0 and writes have no effect.
- Registers (offset from base):
  - 0x00 CTRL, RW: [3:0] idx, [8] en. Byte-lane writes honour wbs_sel_i.
  - 0x04 STATUS, RO: [15:0] active_o zero-extended; [16] busy; [18:17] FSM state encoding.
  - 0x08 SCRATCH, RW: 32 bits, byte-lane writes.
  - 0x0C IO_LO, RO: snapshot of io_in[31:0].
  - 0x10 IO_HI, RO: [5:0] snapshot of io_in[37:32].
- io_in path: 2-flop synchronizer on every bit. The snapshot register loads the synchronized value every cycle except the ack cycle of an IO_LO read. That freezes IO_HI for a following read, so a coherent 38-bit pair is available to firmware.
- Target: target_valid = en & (idx < NUM_PROJECTS). It is evaluated from the post-write CTRL value in the cycle after the write ack.
- FSM states:
  - OFF: active_o=0. Moves to GUARD when target_valid.
  - GUARD: active_o=0, busy_o=1. A down-counter loads GUARD_CYCLES-1 on entry and decrements each cycle. At 0 it goes to ON, with active_o = 1<<idx on the next cycle.
  - ON: active_o one-hot at the latched index.
- FSM transitions on a CTRL change:
  - In ON, a change to a different valid target → GUARD. active_o drops to 0 in the cycle after the write ack.
  - In ON, writing the same idx with en=1 → no change, and no guard is inserted.
  - From any state, target invalid (en=0 or idx out of range) → OFF, active_o=0 in the next cycle.
  - In GUARD, a valid write reloads the counter and latches the new idx, so the guard restarts.
- CTRL readback returns the value as written, including an out-of-range idx.
- Invariants: popcount(active_o) ≤ 1 at all times. active_o never moves directly from one non-zero value to another.
- Reset mid-transaction: ack and the FSM clear immediately. A pending bus cycle is not acked; the master times out.

Decomposition:
- Package wb_project_selector_pkg holds:
  - register offset constants (OFF_CTRL, OFF_STATUS, OFF_SCRATCH, OFF_IO_LO, OFF_IO_HI);
  - the CTRL field bit positions;
  - the FSM state enum (OFF=2'd0, GUARD=2'd1, ON=2'd2).
- One sub-module, sel_guard_fsm. It takes target_valid, idx and load and produces active_o and busy_o. The Wishbone decode and registers stay in the top level.

Test Plan:
- Reset then read STATUS → ack 1 cycle after stb; data 32'h0; active_o=0.
- Write CTRL=0x103 with GUARD_CYCLES=16 → busy_o high for 16 cycles, then active_o=8'h08, STATUS reads 0x0004_0008.
- From ON at idx 3, write CTRL=0x105 → active_o=0 for 16 cycles, then 8'h20; a per-cycle assertion confirms it never reaches 8'h28.
- Write CTRL=0x10A (idx 10 ≥ 8) → active_o stays 0, FSM OFF, CTRL readback 0x10A. Write CTRL=0x000 while in GUARD → OFF next cycle.
- Write SCRATCH=0xDEADBEEF with sel=4'b0101 after reset → readback 0x00AD00EF. Read offset 0x20 → acked, data 0. Address outside BASE → no ack.
- Drive io_in=38'h2A_1234_5678, wait 3 cycles, read IO_LO then change io_in, then read IO_HI → 0x12345678 then 0x2A.
